// File: rtl/snic_boot_ctrl.sv
// snic_boot_ctrl: host AXI-Lite control/status block that sequences the soft core
// through HALT / RESET_HOLD / RUN and drives a guaranteed-width core reset.
module snic_boot_ctrl #(
  parameter int ADDR_W           = 32,
  parameter int RST_HOLD_DEFAULT = 16,
  parameter int CNT_W            = 16
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              core_rst_out,
  output logic              core_running
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] rst_cycles_r;
  logic [31:0]      boot_cnt_r;
  logic             run_r;
  logic             soft_r;
  logic             core_rst_out_r;
  logic             core_running_r;

  logic             aw_full_r;
  logic             w_full_r;
  logic [1:0]       wsel_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;
  logic             awready_r;
  logic             wready_r;
  logic             bvalid_r;
  logic [1:0]       bresp_r;

  logic             arready_r;
  logic             rvalid_r;
  logic [31:0]      rdata_r;
  logic [1:0]       rresp_r;

  logic             commit_s;
  logic             ctrl_wr_s;
  logic             rc_wr_s;
  logic             ro_wr_s;
  logic [31:0]      wmask_s;
  logic [CNT_W-1:0] rc_merge_s;
  logic [31:0]      status_s;
  logic [31:0]      rd_mux_s;
  logic             unused_s;

  assign s_awready    = awready_r;
  assign s_wready     = wready_r;
  assign s_bvalid     = bvalid_r;
  assign s_bresp      = bresp_r;
  assign s_arready    = arready_r;
  assign s_rvalid     = rvalid_r;
  assign s_rdata      = rdata_r;
  assign s_rresp      = rresp_r;
  assign core_rst_out = core_rst_out_r;
  assign core_running = core_running_r;

  // Address bits outside [3:2] and data bits beyond the register widths are don't-care.
  assign unused_s = ^{s_awaddr, s_araddr, wdata_r, wmask_s};

  // Decode the captured write and build the byte-merged RESET_CYCLES value.
  always_comb begin
    commit_s   = aw_full_r & w_full_r & ~bvalid_r;
    ctrl_wr_s  = 1'b0;
    rc_wr_s    = 1'b0;
    ro_wr_s    = 1'b0;
    wmask_s    = {{8{wstrb_r[3]}}, {8{wstrb_r[2]}}, {8{wstrb_r[1]}}, {8{wstrb_r[0]}}};
    rc_merge_s = (rst_cycles_r & ~wmask_s[CNT_W-1:0]) | (wdata_r[CNT_W-1:0] & wmask_s[CNT_W-1:0]);
    case (wsel_r)
      2'd0:       ctrl_wr_s = commit_s & wstrb_r[0];
      2'd2:       rc_wr_s   = commit_s;
      2'd1, 2'd3: ro_wr_s   = commit_s;
      default:    ro_wr_s   = 1'b0;
    endcase
  end

  // Read-side register mux; STATUS reflects the registered outputs.
  always_comb begin
    status_s = {22'd0, state_r, 6'd0, core_rst_out_r, core_running_r};
    case (s_araddr[3:2])
      2'd0:    rd_mux_s = {31'd0, run_r};
      2'd1:    rd_mux_s = status_s;
      2'd2:    rd_mux_s = 32'(rst_cycles_r);
      2'd3:    rd_mux_s = boot_cnt_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Write channel: independent AW/W capture, commit one cycle later, B held until bready.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      wsel_r    <= 2'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      if (s_awvalid && awready_r) begin
        aw_full_r <= 1'b1;
        awready_r <= 1'b0;
        wsel_r    <= s_awaddr[3:2];
      end
      if (s_wvalid && wready_r) begin
        w_full_r <= 1'b1;
        wready_r <= 1'b0;
        wdata_r  <= s_wdata;
        wstrb_r  <= s_wstrb;
      end
      if (commit_s) begin
        aw_full_r <= 1'b0;
        w_full_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= ro_wr_s ? 2'b10 : 2'b00;
      end else if (bvalid_r && s_bready) begin
        bvalid_r  <= 1'b0;
        awready_r <= 1'b1;
        wready_r  <= 1'b1;
      end
    end
  end

  // Host-writable registers; SOFT_RST lives for exactly one cycle after its commit.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      run_r        <= 1'b0;
      soft_r       <= 1'b0;
      rst_cycles_r <= CNT_W'(RST_HOLD_DEFAULT);
    end else begin
      soft_r <= 1'b0;
      if (ctrl_wr_s) begin
        run_r  <= wdata_r[0];
        soft_r <= wdata_r[0] & wdata_r[1];
      end
      if (rc_wr_s) begin
        rst_cycles_r <= rc_merge_s;
      end
    end
  end

  // Life-cycle FSM with outputs registered alongside the state.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_r        <= ST_HALT;
      hold_cnt_r     <= {CNT_W{1'b0}};
      boot_cnt_r     <= 32'd0;
      core_rst_out_r <= 1'b1;
      core_running_r <= 1'b0;
    end else begin
      case (state_r)
        ST_HALT: begin
          if (run_r) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= rst_cycles_r;
          end
        end
        ST_HOLD: begin
          if (!run_r) begin
            state_r <= ST_HALT;
          end else if (hold_cnt_r == {CNT_W{1'b0}}) begin
            state_r        <= ST_RUN;
            boot_cnt_r     <= boot_cnt_r + 32'd1;
            core_rst_out_r <= 1'b0;
            core_running_r <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - CNT_W'(1'b1);
          end
        end
        ST_RUN: begin
          if (!run_r) begin
            state_r        <= ST_HALT;
            core_rst_out_r <= 1'b1;
            core_running_r <= 1'b0;
          end else if (soft_r) begin
            state_r        <= ST_HOLD;
            hold_cnt_r     <= rst_cycles_r;
            core_rst_out_r <= 1'b1;
            core_running_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_HALT;
          core_rst_out_r <= 1'b1;
          core_running_r <= 1'b0;
        end
      endcase
    end
  end

  // Read channel: single outstanding read, data held until rready.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= 2'b00;
    end else if (s_arvalid && arready_r) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b1;
      rdata_r   <= rd_mux_s;
      rresp_r   <= 2'b00;
    end else if (rvalid_r && s_rready) begin
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snic_boot_ctrl.sv
// Self-checking bench for snic_boot_ctrl: table vectors, directed life-cycle
// sequences, and a random register-traffic phase against a timestamp model.
module tb_snic_boot_ctrl;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        core_rst_out, core_running;

  snic_boot_ctrl dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .core_rst_out(core_rst_out), .core_running(core_running)
  );

  always #5 core_clk = ~core_clk;

  longint cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: timestamps of the current boot sequence (HOLD starts at m_hs, lasts m_hl).
  int     m_run, m_rc, m_boots;
  longint m_hs, m_hl;

  function automatic int m_state(input longint k);
    if (m_run == 0) return 0;
    if (k >= m_hs + m_hl) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] m_status(input longint k);
    int st;
    st = m_state(k);
    return (32'(st) << 8) | ((st != 2) ? 32'h2 : 32'h0) | ((st == 2) ? 32'h1 : 32'h0);
  endfunction

  function automatic logic [31:0] m_boot(input longint k);
    return 32'(m_boots + ((m_run != 0 && k >= m_hs + m_hl) ? 1 : 0));
  endfunction

  task automatic model_init();
    m_run = 0; m_rc = 16; m_boots = 0; m_hs = 0; m_hl = 0;
  endtask

  task automatic model_ctrl(input logic [31:0] d, input logic [3:0] strb, input longint c);
    int nr, ns;
    nr = d[0] ? 1 : 0;
    ns = (d[0] && d[1]) ? 1 : 0;
    if (strb[0]) begin
      if (m_run != 0) begin
        if (nr == 0) begin
          if (c >= m_hs + m_hl) m_boots++;
          m_run = 0;
        end else if (ns != 0 && c >= m_hs + m_hl) begin
          m_boots++;
          m_hs = c + 1; m_hl = m_rc + 1;
        end
      end else if (nr != 0) begin
        m_run = 1; m_hs = c + 1; m_hl = m_rc + 1;
      end
    end
  endtask

  task automatic model_rc(input logic [31:0] d, input logic [3:0] strb);
    if (strb[0]) m_rc = (m_rc & 32'hFF00) | int'(d & 32'h00FF);
    if (strb[1]) m_rc = (m_rc & 32'h00FF) | int'(d & 32'hFF00);
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
    s_awaddr = 32'd0; s_araddr = 32'd0; s_wdata = 32'd0; s_wstrb = 4'd0;
    repeat (3) @(negedge core_clk);
    core_rst = 1'b0;
  endtask

  // Returns at the negedge after the B handshake; c is the commit edge (bvalid rise).
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output longint c);
    int n;
    @(negedge core_clk);
    s_awvalid = 1'b1; s_awaddr = addr; s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
    n = 0;
    while (!(s_awready && s_wready) && n < 50) begin @(negedge core_clk); n++; end
    if (n >= 50) tmo("aw_w_ready");
    @(negedge core_clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 50) begin @(negedge core_clk); n++; end
    if (n >= 50) tmo("bvalid");
    c = cyc;
    resp = s_bresp;
    s_bready = 1'b1;
    @(negedge core_clk);
    s_bready = 1'b0;
  endtask

  // k is the edge whose register values the read returns; lat counts cycles to rvalid.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output longint k, output int lat);
    int n;
    @(negedge core_clk);
    s_arvalid = 1'b1; s_araddr = addr;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge core_clk); n++; end
    if (n >= 50) tmo("arready");
    k = cyc;
    @(negedge core_clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 50) begin @(negedge core_clk); lat++; end
    if (lat >= 50) tmo("rvalid");
    data = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(negedge core_clk);
    s_rready = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] r; longint k; int lat;
    axi_read(addr, d, r, k, lat);
    chk(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r; longint c;
    axi_write(addr, data, 4'hF, r, c);
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    while (core_rst_out && n < 1000) begin n++; @(negedge core_clk); end
  endtask

  typedef struct {
    logic [31:0] waddr; logic [31:0] wdata; logic [3:0] wstrb; logic [1:0] bresp;
    logic [31:0] raddr; logic [31:0] rdata;
  } vec_t;
  vec_t vecs[9];

  logic mon_en = 1'b0;
  logic saw_run = 1'b0;
  always @(negedge core_clk) if (mon_en && core_running) saw_run <= 1'b1;

  initial begin
    logic [31:0] d, rd;
    logic [1:0]  rr, br;
    longint      c, k;
    int          lat, n;

    vecs[0] = '{32'h8, 32'h0000_1234, 4'hF, 2'b00, 32'h8, 32'h0000_1234};
    vecs[1] = '{32'h8, 32'hABCD_5678, 4'h1, 2'b00, 32'h8, 32'h0000_1278};
    vecs[2] = '{32'h8, 32'hFFFF_9A00, 4'h2, 2'b00, 32'h8, 32'h0000_9A78};
    vecs[3] = '{32'h4, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h4, 32'h0000_0002};
    vecs[4] = '{32'hC, 32'h0000_0055, 4'hF, 2'b10, 32'hC, 32'h0000_0000};
    vecs[5] = '{32'h0, 32'h0000_0002, 4'hF, 2'b00, 32'h0, 32'h0000_0000};
    vecs[6] = '{32'h3, 32'h0000_0000, 4'hF, 2'b00, 32'h5, 32'h0000_0002};
    vecs[7] = '{32'h0, 32'h0000_0001, 4'hE, 2'b00, 32'h4, 32'h0000_0002};
    vecs[8] = '{32'hA, 32'hFFFF_0010, 4'h3, 2'b00, 32'h8, 32'h0000_0010};

    // Reset values and first read
    do_reset();
    chk("rst_core_rst_out", {31'd0, core_rst_out}, 32'd1);
    chk("rst_core_running", {31'd0, core_running}, 32'd0);
    chk("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);
    chk("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    axi_read(32'h4, rd, rr, k, lat);
    chk("rst_status", rd, 32'h0000_0002);
    chk("rst_rresp", {30'd0, rr}, 32'd0);
    chk("rd_latency", 32'(lat), 32'd1);

    // Table-driven write/readback in HALT
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, br, c);
      chk($sformatf("tbl%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].bresp});
      rd_chk($sformatf("tbl%0d_rdata", i), vecs[i].raddr, vecs[i].rdata);
    end

    // Boot from HALT with RESET_CYCLES=16
    wr(32'h0, 32'h1);
    pulse_len(n);
    chk("boot_pulse_len", 32'(n), 32'd17);
    chk("boot_running", {31'd0, core_running}, 32'd1);
    rd_chk("boot_count1", 32'hC, 32'd1);
    rd_chk("boot_status", 32'h4, 32'h0000_0201);

    // Soft reset from RUN
    wr(32'h0, 32'h3);
    chk("soft_rst_immediate", {31'd0, core_rst_out}, 32'd1);
    pulse_len(n);
    chk("soft_pulse_len", 32'(n), 32'd17);
    rd_chk("boot_count2", 32'hC, 32'd2);
    rd_chk("ctrl_soft_reads0", 32'h0, 32'd1);

    // Minimum pulse with RESET_CYCLES=0, read-only write
    wr(32'h8, 32'h0);
    wr(32'h0, 32'h0);
    wr(32'h0, 32'h1);
    pulse_len(n);
    chk("min_pulse_len", 32'(n), 32'd1);
    rd_chk("boot_count3", 32'hC, 32'd3);
    axi_write(32'hC, 32'h7, 4'hF, br, c);
    chk("bootcnt_wr_bresp", {30'd0, br}, 32'd2);
    rd_chk("bootcnt_unchanged", 32'hC, 32'd3);

    // AW three cycles ahead of W, bready held low for five cycles
    @(negedge core_clk);
    s_awvalid = 1'b1; s_awaddr = 32'h8;
    @(negedge core_clk);
    s_awvalid = 1'b0;
    repeat (2) begin
      chk("split_aw_wait", {29'd0, s_awready, s_wready, s_bvalid}, 32'b010);
      @(negedge core_clk);
    end
    s_wvalid = 1'b1; s_wdata = 32'h5; s_wstrb = 4'hF;
    @(negedge core_clk);
    s_wvalid = 1'b0;
    chk("split_no_early_b", {31'd0, s_bvalid}, 32'd0);
    @(negedge core_clk);
    repeat (5) begin
      chk("split_b_hold", {28'd0, s_bvalid, s_bresp, s_awready, s_wready}, 32'b10000);
      @(negedge core_clk);
    end
    s_bready = 1'b1;
    @(negedge core_clk);
    s_bready = 1'b0;
    chk("split_after_b", {29'd0, s_bvalid, s_awready, s_wready}, 32'b011);
    rd_chk("split_rc", 32'h8, 32'd5);

    // Clear RUN in the middle of a long HOLD
    wr(32'h0, 32'h0);
    wr(32'h8, 32'd100);
    wr(32'h0, 32'h1);
    saw_run = 1'b0; mon_en = 1'b1;
    repeat (49) @(negedge core_clk);
    wr(32'h0, 32'h0);
    repeat (150) @(negedge core_clk);
    mon_en = 1'b0;
    chk("abort_never_running", {31'd0, saw_run}, 32'd0);
    chk("abort_rst_out", {31'd0, core_rst_out}, 32'd1);
    rd_chk("abort_status", 32'h4, 32'h0000_0002);
    rd_chk("abort_boot_count", 32'hC, 32'd3);

    // STATUS read landing on the CTRL commit cycle sees the pre-write value
    fork
      axi_write(32'h0, 32'h1, 4'hF, br, c);
      begin
        @(negedge core_clk);
        axi_read(32'h4, rd, rr, k, lat);
      end
    join
    chk("overlap_status", rd, 32'h0000_0002);
    rd_chk("overlap_hold", 32'h4, 32'h0000_0102);

    // core_rst with an AW beat pending
    @(negedge core_clk);
    s_awvalid = 1'b1; s_awaddr = 32'h0;
    @(negedge core_clk);
    s_awvalid = 1'b0;
    chk("pend_aw_captured", {31'd0, s_awready}, 32'd0);
    core_rst = 1'b1;
    @(negedge core_clk);
    core_rst = 1'b0;
    chk("pend_reset_ifc", {27'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 32'b11100);
    chk("pend_reset_core", {30'd0, core_rst_out, core_running}, 32'b10);
    rd_chk("pend_reset_rc", 32'h8, 32'd16);
    rd_chk("pend_reset_ctrl", 32'h0, 32'd0);

    // Random register traffic against the timestamp model
    do_reset();
    model_init();
    for (int i = 0; i < 120; i++) begin
      int op;
      logic [3:0] strb;
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 7));
          strb = 4'($urandom_range(0, 15));
          axi_write(32'h8 | 32'($urandom_range(0, 3)), d, strb, br, c);
          model_rc(d, strb);
          chk("rnd_rc_bresp", {30'd0, br}, 32'd0);
        end
        1: begin
          d = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
          strb = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 1));
          axi_write(32'h0 | 32'($urandom_range(0, 3)), d, strb, br, c);
          model_ctrl(d, strb, c);
          chk("rnd_ctrl_bresp", {30'd0, br}, 32'd0);
        end
        2: begin
          axi_write(($urandom_range(0, 1) != 0 ? 32'h4 : 32'hC), $urandom(), 4'hF, br, c);
          chk("rnd_ro_bresp", {30'd0, br}, 32'd2);
        end
        3: begin
          int sel;
          logic [31:0] exp;
          sel = $urandom_range(0, 3);
          axi_read(32'(sel * 4 + $urandom_range(0, 3)), rd, rr, k, lat);
          case (sel)
            0:       exp = 32'(m_run);
            1:       exp = m_status(k);
            2:       exp = 32'(m_rc);
            default: exp = m_boot(k);
          endcase
          chk($sformatf("rnd_read_reg%0d", sel), rd, exp);
          chk("rnd_rresp", {30'd0, rr}, 32'd0);
        end
        default: begin
          repeat ($urandom_range(0, 12)) @(negedge core_clk);
        end
      endcase
      chk("rnd_core_running", {31'd0, core_running}, (m_state(cyc) == 2) ? 32'd1 : 32'd0);
      chk("rnd_core_rst_out", {31'd0, core_rst_out}, (m_state(cyc) != 2) ? 32'd1 : 32'd0);
    end
    rd_chk("rnd_final_boot", 32'hC, m_boot(cyc + 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
